harpoon_ctrl: RTL

Harpoon (shot) controller for player 1. Runs on the per-frame clock alongside the player movement block. Sequences the single harpoon resource: fire-key detection across all four keycode slots, launch from the player's current X, per-frame upward extension, and termination on ceiling or ball hit. Enforces a cooldown. Supplies harpoon geometry to the draw/collision logic and a one-frame pop request to the ball logic.

---
 rtl/bt_pkg.sv | 28 ++
 rtl/fire_key_detect.sv | 31 +++
 rtl/harpoon_ctrl.sv | 94 +++++++++
 3 files changed

// File: rtl/bt_pkg.sv
// Shared playfield, keycode and harpoon definitions.
// Used by the player, ball and harpoon blocks.
package bt_pkg;

  localparam logic [7:0] KEY_FIRE  = 8'h2C;
  localparam logic [7:0] KEY_LEFT  = 8'h50;
  localparam logic [7:0] KEY_RIGHT = 8'h4F;

  localparam logic [9:0] FLOOR_Y  = 10'd400;
  localparam logic [9:0] CEIL_Y   = 10'd10;
  localparam logic [9:0] STEP     = 10'd6;
  localparam logic [9:0] X_OFFSET = 10'd21;

  localparam logic [3:0] COOLDOWN_FRAMES = 4'd8;

  typedef enum logic [1:0] {
    IDLE,
    EXTEND,
    COOLDOWN
  } harpoon_state_t;

  function automatic logic is_fire(
    input logic [7:0] k
  );
    return k == KEY_FIRE;
  endfunction

endpackage

// File: rtl/fire_key_detect.sv
// Fire key match over all four USB slots.
// Emits a single-frame rising edge of the fire key.
module fire_key_detect
  import bt_pkg::*;
(
  input  logic       frame_clk,
  input  logic       Reset_n,
  input  logic [7:0] keycode,
  input  logic [7:0] keycode2,
  input  logic [7:0] keycode3,
  input  logic [7:0] keycode4,
  output logic       fire_edge
);

  logic fire_now;
  logic fire_prev;

  assign fire_now = is_fire(keycode)
                  | is_fire(keycode2)
                  | is_fire(keycode3)
                  | is_fire(keycode4);

  // remember last frame's key level so a held key fires once
  always_ff @(posedge frame_clk or negedge Reset_n) begin
    if (!Reset_n) fire_prev <= 1'b0;
    else          fire_prev <= fire_now;
  end

  assign fire_edge = fire_now & ~fire_prev;

endmodule

// File: rtl/harpoon_ctrl.sv
// Player 1 harpoon sequencer: launch, extend,
// terminate on hit or ceiling, then cooldown.
module harpoon_ctrl
  import bt_pkg::*;
(
  input  logic       frame_clk,
  input  logic       Reset_n,
  input  logic [7:0] keycode,
  input  logic [7:0] keycode2,
  input  logic [7:0] keycode3,
  input  logic [7:0] keycode4,
  input  logic [1:0] game_on,
  input  logic [9:0] PlayerX,
  input  logic       harpoon_hit,
  output logic [9:0] HarpoonX,
  output logic [9:0] HarpoonTop,
  output logic       harpoon_active,
  output logic       pop_req,
  output logic [7:0] shots
);

  harpoon_state_t state;
  logic [3:0]     cnt;
  logic           fire_edge;

  fire_key_detect u_fire (
    .frame_clk (frame_clk),
    .Reset_n   (Reset_n),
    .keycode   (keycode),
    .keycode2  (keycode2),
    .keycode3  (keycode3),
    .keycode4  (keycode4),
    .fire_edge (fire_edge)
  );

  // shot FSM with registered geometry and pop pulse
  always_ff @(posedge frame_clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state          <= IDLE;
      cnt            <= '0;
      HarpoonX       <= '0;
      HarpoonTop     <= FLOOR_Y;
      harpoon_active <= 1'b0;
      pop_req        <= 1'b0;
      shots          <= '0;
    end else begin
      pop_req <= 1'b0;
      if (game_on == 2'd0) begin
        state          <= IDLE;
        cnt            <= '0;
        HarpoonTop     <= FLOOR_Y;
        harpoon_active <= 1'b0;
        shots          <= '0;
      end else begin
        unique case (state)
          IDLE: begin
            if (fire_edge) begin
              state          <= EXTEND;
              HarpoonX       <= PlayerX + X_OFFSET;
              HarpoonTop     <= FLOOR_Y;
              harpoon_active <= 1'b1;
              if (shots != 8'hFF) shots <= shots + 8'd1;
            end
          end
          EXTEND: begin
            if (harpoon_hit) begin
              pop_req        <= 1'b1;
              harpoon_active <= 1'b0;
              cnt            <= COOLDOWN_FRAMES;
              state          <= COOLDOWN;
            end else if (HarpoonTop < CEIL_Y + STEP) begin
              HarpoonTop     <= CEIL_Y;
              harpoon_active <= 1'b0;
              cnt            <= COOLDOWN_FRAMES;
              state          <= COOLDOWN;
            end else begin
              HarpoonTop <= HarpoonTop - STEP;
            end
          end
          COOLDOWN: begin
            if (cnt == 4'd1) begin
              cnt   <= '0;
              state <= IDLE;
            end else begin
              cnt <= cnt - 4'd1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
